// File: rtl/ysyx_24100006_stage_fifo.sv
// Inter-stage pipeline buffer with valid/ready handshake, flush and redirect squash.
// Optional STAGE_FIFO_PERF_EN adds stall/bubble performance counters.
module ysyx_24100006_stage_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_redir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_redir,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  count_o
`ifdef STAGE_FIFO_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       bubble_cnt_o
`endif
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  redir_q;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_next;
  logic [PTR_W-1:0]  wr_next;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic              squash;

  // in_ready looks only at registered occupancy, so out_ready never reaches it.
  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];
  assign out_redir = redir_q[rd_ptr];
  assign squash    = pop & out_redir;
  assign count_o   = count;

  assign rd_next = (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
  assign wr_next = (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      redir_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush_i) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (squash) begin
      // Everything behind the redirecting head is wrong-path; restart empty after it.
      count  <= '0;
      rd_ptr <= rd_next;
      wr_ptr <= rd_next;
    end else begin
      if (push) begin
        mem[wr_ptr]     <= in_data;
        redir_q[wr_ptr] <= in_redir;
        wr_ptr          <= wr_next;
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

`ifdef STAGE_FIFO_PERF_EN
  // Counters survive flush on purpose; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (out_valid && !out_ready) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
      if (!out_valid && out_ready) begin
        bubble_cnt_o <= bubble_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule
